velocity_cell_dbuf: RTL and testbench

- Per-cell velocity store, next generation of the single-port per-cell velocity RAM.
- Double-buffered: two banks of {vz, vy, vx} words.
  - The "current" bank serves reads to the force-evaluation/motion-update pipeline.
  - The "next" bank takes write-back of updated velocities.
- A swap pulse at the iteration boundary exchanges the banks.
- Address 0 of each bank holds the cell particle count, shadowed in a register.

---
 rtl/md_vel_pkg.sv | 29 ++
 rtl/vel_bank_ram.sv | 55 +++++
 rtl/velocity_cell_dbuf.sv | 124 ++++++++++++
 tb/tb_velocity_cell_dbuf.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/md_vel_pkg.sv
// Shared constants for the per-cell velocity store: component width,
// word-packing offsets for {vz, vy, vx} and the particle-count address.
package md_vel_pkg;

    localparam int COMP_WIDTH = 32;

    // Bit offsets of each component inside a packed velocity word.
    localparam int VX_LSB = 0;
    localparam int VY_LSB = COMP_WIDTH;
    localparam int VZ_LSB = 2 * COMP_WIDTH;

    // Word 0 of each bank holds the particle count rather than a velocity.
    localparam int COUNT_ADDR = 0;

    // Pack three single-float components into one {vz, vy, vx} word.
    function automatic logic [3*COMP_WIDTH-1:0] pack_vel(
        input logic [COMP_WIDTH-1:0] vz,
        input logic [COMP_WIDTH-1:0] vy,
        input logic [COMP_WIDTH-1:0] vx
    );
        logic [3*COMP_WIDTH-1:0] w;
        w = '0;
        w[VZ_LSB +: COMP_WIDTH] = vz;
        w[VY_LSB +: COMP_WIDTH] = vy;
        w[VX_LSB +: COMP_WIDTH] = vx;
        return w;
    endfunction

endpackage

// File: rtl/vel_bank_ram.sv
// One velocity bank: simple dual-port synchronous RAM with a registered
// read port. A read and a write to the same address in one cycle return
// the data stored before the write.
module vel_bank_ram #(
    parameter int DEPTH = 220,
    parameter int WIDTH = 96,
    parameter int AW    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_d;
    logic [WIDTH-1:0] rdata_q;

    // Storage array write port.
    // NOTE: the array has no reset so it maps onto RAM macros; only the
    // output register is reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignment here is what makes a same-cycle read
        // see the pre-write contents.
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read port: capture a new word on re, otherwise hold the last one.
    always_comb begin
        // NOTE: every comb output gets its hold value first so no path can
        // leave it unassigned and infer a latch.
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem[raddr];
        end
    end

    // Registered read output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/velocity_cell_dbuf.sv
// Double-buffered per-cell velocity store. The current bank serves reads,
// the next bank takes write-back; swap exchanges them at an iteration
// boundary. Word 0 of each bank is the particle count, shadowed in a
// register per bank so the current count is always available.
module velocity_cell_dbuf #(
    parameter int COMP_WIDTH   = md_vel_pkg::COMP_WIDTH,
    parameter int DATA_WIDTH   = 3 * COMP_WIDTH,
    parameter int PARTICLE_NUM = 220,
    parameter int ADDR_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  init_mode,
    input  logic                  swap,
    output logic                  bank_sel,
    output logic [ADDR_WIDTH-1:0] cur_count,
    output logic                  err
);

    localparam logic [ADDR_WIDTH-1:0] CNT_ADDR = ADDR_WIDTH'(md_vel_pkg::COUNT_ADDR);

    logic                  bank_sel_d, bank_sel_q;
    logic                  rd_valid_d, rd_valid_q;
    logic                  rd_bank_d,  rd_bank_q;
    logic                  rd_zero_d,  rd_zero_q;
    logic                  err_d,      err_q;
    logic [ADDR_WIDTH-1:0] count_d [2];
    logic [ADDR_WIDTH-1:0] count_q [2];

    logic                  rd_in_range;
    logic                  wr_in_range;
    logic                  wr_bank;
    logic [DATA_WIDTH-1:0] bank_rdata [2];

    assign rd_in_range = (32'(rd_addr) < PARTICLE_NUM);
    assign wr_in_range = (32'(wr_addr) < PARTICLE_NUM);

    // Host preload writes the current bank; write-back goes to the next one.
    assign wr_bank = init_mode ? bank_sel_q : ~bank_sel_q;

    // Two physical banks; enables use the pre-swap bank_sel so a swap-cycle
    // access still lands on the old roles.
    for (genvar b = 0; b < 2; b++) begin : g_bank
        logic bank_we;
        logic bank_re;

        assign bank_we = wr_en && wr_in_range && (wr_bank == 1'(b));
        assign bank_re = rd_en && rd_in_range && (bank_sel_q == 1'(b));

        vel_bank_ram #(
            .DEPTH (PARTICLE_NUM),
            .WIDTH (DATA_WIDTH),
            .AW    (ADDR_WIDTH)
        ) u_ram (
            .clk   (clk),
            .rst_n (rst_n),
            .we    (bank_we),
            .waddr (wr_addr),
            .wdata (wr_data),
            .re    (bank_re),
            .raddr (rd_addr),
            .rdata (bank_rdata[b])
        );
    end

    // Next-state for bank selection, read tracking, count shadows and err.
    always_comb begin
        bank_sel_d = bank_sel_q ^ swap;
        rd_valid_d = rd_en;
        rd_bank_d  = rd_bank_q;
        rd_zero_d  = rd_zero_q;
        err_d      = err_q;
        count_d    = count_q;

        // Remember which bank answered and whether the read was out of range,
        // so rd_data holds its last value while rd_en is low.
        if (rd_en) begin
            rd_bank_d = bank_sel_q;
            rd_zero_d = ~rd_in_range;
        end

        if ((rd_en && !rd_in_range) || (wr_en && !wr_in_range)) begin
            err_d = 1'b1;
        end

        // A count write in a swap cycle updates the pre-swap target shadow.
        if (wr_en && wr_in_range && (wr_addr == CNT_ADDR)) begin
            count_d[wr_bank] = wr_data[ADDR_WIDTH-1:0];
        end
    end

    // Control and shadow registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_sel_q <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_bank_q  <= 1'b0;
            rd_zero_q  <= 1'b1;
            err_q      <= 1'b0;
            count_q    <= '{default: '0};
        end else begin
            bank_sel_q <= bank_sel_d;
            rd_valid_q <= rd_valid_d;
            rd_bank_q  <= rd_bank_d;
            rd_zero_q  <= rd_zero_d;
            err_q      <= err_d;
            count_q    <= count_d;
        end
    end

    assign rd_data   = rd_zero_q ? '0 : bank_rdata[rd_bank_q];
    assign rd_valid  = rd_valid_q;
    assign bank_sel  = bank_sel_q;
    assign cur_count = count_q[bank_sel_q];
    assign err       = err_q;

endmodule

// File: tb/tb_velocity_cell_dbuf.sv
// Directed bench for velocity_cell_dbuf: preload, write-back, swap, count
// shadow, range errors, read-during-write and reset during a read burst.
module tb_velocity_cell_dbuf;

    localparam int DW = 96;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          init_mode;
    logic          swap;
    logic          bank_sel;
    logic [AW-1:0] cur_count;
    logic          err;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [DW-1:0] W1  = 96'h3F800000_40000000_40400000;
    localparam logic [DW-1:0] WA  = 96'hAAAAAAAA_AAAAAAAA_AAAAAAAA;
    localparam logic [DW-1:0] W3  = 96'h11111111_22222222_33333333;
    localparam logic [DW-1:0] W3B = 96'h44444444_55555555_66666666;
    localparam logic [DW-1:0] WFF = 96'hFFFFFFFF_FFFFFFFF_FFFFFFFF;

    velocity_cell_dbuf dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .init_mode (init_mode),
        .swap      (swap),
        .bank_sel  (bank_sel),
        .cur_count (cur_count),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Burst pattern for addresses 1..8: distinct per address and component.
    function automatic logic [DW-1:0] burst_word(input int i);
        return {32'hC0DE0000 + 32'(i), 32'hBEEF0000 + 32'(i), 32'hF00D0000 + 32'(i)};
    endfunction

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rd_en = 1'b0; wr_en = 1'b0; swap = 1'b0;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    task automatic do_read(input logic [AW-1:0] a);
        rd_en = 1'b1; rd_addr = a;
        step();
        rd_en = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; rd_en = 1'b0; rd_addr = '0; wr_en = 1'b0; wr_addr = '0;
        wr_data = '0; init_mode = 1'b0; swap = 1'b0;

        // Reset state
        #12;
        check("rst_bank_sel",  DW'(bank_sel),  '0);
        check("rst_rd_valid",  DW'(rd_valid),  '0);
        check("rst_rd_data",   rd_data,        '0);
        check("rst_cur_count", DW'(cur_count), '0);
        check("rst_err",       DW'(err),       '0);
        rst_n = 1'b1;

        // 1: host preload of the current bank (bank 0)
        init_mode = 1'b1;
        do_write(8'd0, 96'd5);
        check("t1_count", DW'(cur_count), 96'd5);
        do_write(8'd1, W1);
        do_read(8'd1);
        check("t1_rd_valid", DW'(rd_valid), 96'd1);
        check("t1_rd_data",  rd_data,       W1);
        check("t1_bank_sel", DW'(bank_sel), 96'd0);
        step();
        check("t1_valid_drop", DW'(rd_valid), 96'd0);
        check("t1_data_hold",  rd_data,       W1);

        // 2: write-back to next bank, then swap
        init_mode = 1'b0;
        do_write(8'd1, WA);
        do_read(8'd1);
        check("t2_cur_unchanged", rd_data, W1);
        swap = 1'b1;
        step();
        swap = 1'b0;
        check("t2_bank_sel", DW'(bank_sel),  96'd1);
        check("t2_count",    DW'(cur_count), 96'd0);
        do_read(8'd1);
        check("t2_swapped_data", rd_data, WA);

        // 3: count write to next bank (bank 0) in the swap cycle
        wr_en = 1'b1; wr_addr = 8'd0; wr_data = 96'd9; swap = 1'b1;
        step();
        idle();
        check("t3_bank_sel", DW'(bank_sel),  96'd0);
        check("t3_count",    DW'(cur_count), 96'd9);
        check("t3_err_clear", DW'(err),      96'd0);

        // 4: out-of-range read and write
        do_read(8'd220);
        check("t4_rd_data",  rd_data,       '0);
        check("t4_rd_valid", DW'(rd_valid), 96'd1);
        check("t4_err",      DW'(err),      96'd1);
        init_mode = 1'b1;
        do_write(8'd255, WFF);
        check("t4_count_kept", DW'(cur_count), 96'd9);
        do_read(8'd1);
        check("t4_readback", rd_data,  W1);
        check("t4_err_sticky", DW'(err), 96'd1);
        do_read(8'd0);
        check("t4_count_word", rd_data, 96'd9);
        #2 rst_n = 1'b0;
        #1;
        check("t4_err_reset", DW'(err), '0);
        #2 rst_n = 1'b1;

        // 5: read-during-write on the current bank
        init_mode = 1'b1;
        do_write(8'd3, W3);
        rd_en = 1'b1; rd_addr = 8'd3; wr_en = 1'b1; wr_addr = 8'd3; wr_data = W3B;
        step();
        idle();
        check("t5_old_data", rd_data, W3);
        do_read(8'd3);
        check("t5_new_data", rd_data, W3B);

        // 6: fill bank 1 with a burst pattern, swap, read back-to-back
        init_mode = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            do_write(AW'(i), burst_word(i));
        end
        swap = 1'b1;
        step();
        swap = 1'b0;
        check("t6_bank_sel", DW'(bank_sel), 96'd1);
        for (int i = 1; i <= 3; i++) begin
            rd_en = 1'b1; rd_addr = AW'(i);
            step();
            check($sformatf("t6_valid_%0d", i), DW'(rd_valid), 96'd1);
            check($sformatf("t6_data_%0d", i),  rd_data,       burst_word(i));
        end
        // Reset lands during the 4th read
        rd_addr = 8'd4;
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_valid",    DW'(rd_valid), '0);
        check("t6_rst_bank_sel", DW'(bank_sel), '0);
        rd_en = 1'b0;
        #2 rst_n = 1'b1;
        do_read(8'd1);
        check("t6_post_rst_valid", DW'(rd_valid), 96'd1);
        check("t6_post_rst_bank0", rd_data,       W1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Safety bound so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish within bound");
        $fatal(1, "timeout");
    end

endmodule
